lab8: RTL and testbench

LAB8 -- requirements
Module: lab8

---
 rtl/lab8_pkg.sv | 18 +
 rtl/lab8_mem_array.sv | 29 ++
 rtl/lab8.sv | 99 +++++++++
 tb/tb_lab8.sv | 131 +++++++++++++
 4 files changed

// File: rtl/lab8_pkg.sv
// Shared defaults and state encoding for the lab8 self-clearing single-port RAM.
package lab8_pkg;

    localparam int LAB8_DATA_W = 8;
    localparam int LAB8_ADDR_W = 7;
    localparam int LAB8_DEPTH  = 128;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } lab8_state_e;

    // Index of the final word visited by the clear sequencer.
    function automatic int unsigned lab8_last_index(input int unsigned depth);
        return depth - 32'd1;
    endfunction

endpackage

// File: rtl/lab8_mem_array.sv
// Plain single-port storage: one write port, registered read, no reset, so it maps onto block RAM.
module lab8_mem_array
    import lab8_pkg::*;
#(
    parameter int DATA_W = LAB8_DATA_W,
    parameter int ADDR_W = LAB8_ADDR_W,
    parameter int DEPTH  = LAB8_DEPTH
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read returns the pre-write contents; write-first behaviour is added by the parent.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lab8.sv
// Single-port RAM that zero-fills itself after every reset; busy is high during the fill.
module lab8
    import lab8_pkg::*;
#(
    parameter int DATA_W = LAB8_DATA_W,
    parameter int ADDR_W = LAB8_ADDR_W,
    parameter int DEPTH  = LAB8_DEPTH
) (
    output logic [DATA_W-1:0] q,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    input  logic              we,
    input  logic              clk,
    input  logic              rst,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(lab8_last_index(DEPTH));

    lab8_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              force_zero_q, force_zero_d;
    logic              bypass_q, bypass_d;
    logic [DATA_W-1:0] bypass_data_q, bypass_data_d;

    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] mem_rdata_s;

    lab8_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .addr_i  (mem_addr_s),
        .we_i    (mem_we_s),
        .wdata_i (mem_wdata_s),
        .rdata_o (mem_rdata_s)
    );

    // State, clear pointer and output-select registers; reset restarts the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            clr_addr_q    <= '0;
            force_zero_q  <= 1'b1;
            bypass_q      <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            force_zero_q  <= force_zero_d;
            bypass_q      <= bypass_d;
            bypass_data_q <= bypass_data_d;
        end
    end

    // Next state plus memory port steering; rst gates the write so no word changes under reset.
    always_comb begin
        state_d       = state_q;
        clr_addr_d    = clr_addr_q;
        force_zero_d  = 1'b0;
        bypass_d      = 1'b0;
        bypass_data_d = bypass_data_q;
        mem_addr_s    = a;
        mem_wdata_s   = d;
        mem_we_s      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_addr_s   = clr_addr_q;
                mem_wdata_s  = '0;
                mem_we_s     = ~rst;
                force_zero_d = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                mem_we_s      = we & ~rst;
                bypass_d      = we;
                bypass_data_d = d;
            end
            default: begin
                state_d      = ST_CLEAR;
                clr_addr_d   = '0;
                force_zero_d = 1'b1;
            end
        endcase
    end

    // Every select term is a flop, so q changes only on the clock edge.
    assign q    = force_zero_q ? '0 : (bypass_q ? bypass_data_q : mem_rdata_s);
    assign busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_lab8.sv
// Scoreboard bench for lab8: stimulus queues the expected {busy,q}, a negedge monitor compares.
module tb_lab8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we  = 1'b0;
    logic [6:0] a   = 7'd0;
    logic [7:0] d   = 8'd0;
    logic [7:0] q;
    logic       busy;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         edge_n;
        logic [7:0] exp_q;
        logic       exp_busy;
        string      name;
    } exp_t;

    exp_t sb[$];

    lab8 #(.DATA_W(8), .ADDR_W(7), .DEPTH(128)) dut (
        .q    (q),
        .a    (a),
        .d    (d),
        .we   (we),
        .clk  (clk),
        .rst  (rst),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due at the edge just taken and compare.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (e.edge_n != cyc || q !== e.exp_q || busy !== e.exp_busy) begin
                n_fail++;
                $display("FAIL %s edge %0d: got busy=%b q=0x%02h, expected busy=%b q=0x%02h",
                         e.name, cyc, busy, q, e.exp_busy, e.exp_q);
            end
        end
    end

    // Drive inputs for the next edge and queue the outputs expected after it.
    task automatic step(input logic r, input logic w, input logic [6:0] aa, input logic [7:0] dd,
                        input logic eb, input logic [7:0] eq, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        we  = w;
        a   = aa;
        d   = dd;
        e.edge_n   = cyc + 1;
        e.exp_q    = eq;
        e.exp_busy = eb;
        e.name     = nm;
        sb.push_back(e);
    endtask

    // n cycles of clear with rst low; busy expected to drop on the 128th.
    task automatic clear_cycles(input int n, input logic junk, input string nm);
        for (int i = 1; i <= n; i++) begin
            step(1'b0, junk, junk ? 7'(i) : 7'd0, 8'hEE, (i < 128), 8'h00, nm);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        // First reset edge comes from the initial rst=1; this adds the second.
        step(1'b1, 1'b0, 7'd0, 8'h00, 1'b1, 8'h00, "reset");
        clear_cycles(128, 1'b0, "clear1");

        step(1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00, "rd00_zero");
        step(1'b0, 1'b0, 7'h01, 8'h00, 1'b0, 8'h00, "rd01_zero");
        step(1'b0, 1'b0, 7'h7F, 8'h00, 1'b0, 8'h00, "rd7F_zero");

        step(1'b0, 1'b1, 7'h01, 8'hAA, 1'b0, 8'hAA, "wr01_first");
        step(1'b0, 1'b0, 7'h01, 8'h00, 1'b0, 8'hAA, "rd01_AA");
        step(1'b0, 1'b1, 7'h02, 8'hBB, 1'b0, 8'hBB, "wr02_first");
        step(1'b0, 1'b0, 7'h01, 8'h00, 1'b0, 8'hAA, "rd01_noalias");
        step(1'b0, 1'b0, 7'h02, 8'h00, 1'b0, 8'hBB, "rd02_BB");
        step(1'b0, 1'b1, 7'h7F, 8'h55, 1'b0, 8'h55, "wr7F_first");
        step(1'b0, 1'b0, 7'h7F, 8'h00, 1'b0, 8'h55, "rd7F_55");

        // Reset with a write pending: q forced to 0, write discarded.
        step(1'b1, 1'b1, 7'h05, 8'h99, 1'b1, 8'h00, "rst_q_zero");
        clear_cycles(128, 1'b0, "clear2");
        step(1'b0, 1'b0, 7'h7F, 8'h00, 1'b0, 8'h00, "rd7F_cleared");
        step(1'b0, 1'b0, 7'h01, 8'h00, 1'b0, 8'h00, "rd01_cleared");
        step(1'b0, 1'b0, 7'h05, 8'h00, 1'b0, 8'h00, "rd05_rst_write_dropped");

        // Reset again mid-clear at cycle 60, with junk writes attempted while busy.
        step(1'b0, 1'b1, 7'h03, 8'h33, 1'b0, 8'h33, "wr03_first");
        step(1'b1, 1'b0, 7'h00, 8'h00, 1'b1, 8'h00, "rst3");
        clear_cycles(60, 1'b1, "clear3_partial");
        step(1'b1, 1'b1, 7'h03, 8'h77, 1'b1, 8'h00, "rst_midclear");
        clear_cycles(128, 1'b1, "clear3_restart");

        step(1'b0, 1'b0, 7'h03, 8'h00, 1'b0, 8'h00, "rd03_cleared");
        step(1'b0, 1'b0, 7'h10, 8'h00, 1'b0, 8'h00, "rd10_busy_write_ignored");
        step(1'b0, 1'b0, 7'h7F, 8'h00, 1'b0, 8'h00, "rd7F_busy_write_ignored");
        step(1'b0, 1'b1, 7'h40, 8'hC3, 1'b0, 8'hC3, "wr40_first");
        step(1'b0, 1'b0, 7'h40, 8'h00, 1'b0, 8'hC3, "rd40_C3");

        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
